// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a classic multicycle MIPS-style datapath. Each instruction
// walks FETCH -> DECODE -> (class-specific states) -> FETCH. The FSM stalls in
// the memory states (FETCH, MEMRD, MEMWR) until mem_ready. If mem_ready stays
// low for MEM_TIMEOUT consecutive cycles, the instruction is aborted and
// mem_timeout is pulsed.
//
// Optional feature: define MCC_PERF_CNT_EN to build a 32-bit retired-instruction
// counter on instr_count. Without it, instr_count is tied to zero.
//
// Parameters
//   MEM_TIMEOUT    : maximum consecutive mem_ready=0 cycles before abort (1..255)
//
// Ports
//   CLK            : clock; all state updates on the rising edge
//   rst_n          : asynchronous active-low reset
//   opcode[5:0]    : instruction[31:26] from the instruction register
//   mem_ready      : a memory access completes in the cycle this is high
//   pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
//   mem_toreg, reg_dst, reg_write, alu_src_a : datapath controls
//   pc_src[1:0]    : 0=ALU, 1=ALUOut, 2=ReadData1 (jump)
//   alu_src_b[1:0] : 0=B, 1=const 4, 2=sign-extend, 3=sign-extend<<2
//   alu_op[3:0]    : 0=add 1=sub 2=addi 3=subi 4=andi 5=ori 15=R-type funct
//   state[3:0]     : current state encoding (debug)
//   illegal        : registered one-cycle pulse after an undefined opcode
//   mem_timeout    : registered one-cycle pulse after a memory wait abort
//   instr_count    : retired-instruction count (zero without MCC_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_toreg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic [3:0]  state,
  output logic        illegal,
  output logic        mem_timeout,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b100111;
  localparam logic [5:0] OP_ANDI  = 6'b101111;
  localparam logic [5:0] OP_ORI   = 6'b110010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [5:0] opc_q, opc_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;

  // Raw enables before the reset gate.
  logic pc_write_c, pc_write_cond_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;
  logic waiting;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      opc_q     <= 6'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      opc_q     <= opc_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wait_d          = 8'd0;
    opc_d           = opc_q;
    illegal_d       = 1'b0;
    timeout_d       = 1'b0;
    waiting         = 1'b0;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    ir_write_c      = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    reg_write_c     = 1'b0;
    i_or_d          = 1'b0;
    mem_toreg       = 1'b0;
    reg_dst         = 1'b0;
    alu_src_a       = 1'b0;
    pc_src          = 2'd0;
    alu_src_b       = 2'd0;
    alu_op          = 4'd0;

    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        alu_src_b  = 2'd1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        opc_d     = opcode;
        case (opcode)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_RTYPE:                          state_d = S_EXEC;
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
          OP_BEQ:                            state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opc_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        i_or_d     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else           waiting = 1'b1;
      end
      S_MEMWB: begin
        reg_write_c = 1'b1;
        mem_toreg   = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        i_or_d = 1'b1;
        if (mem_ready) begin
          mem_write_c = 1'b1;
          state_d     = S_FETCH;
        end else begin
          waiting = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 4'd15;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write_c = 1'b1;
        reg_dst     = 1'b1;
        state_d     = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        case (opc_q)
          OP_ADDI: alu_op = 4'd2;
          OP_SUBI: alu_op = 4'd3;
          OP_ANDI: alu_op = 4'd4;
          OP_ORI:  alu_op = 4'd5;
          default: alu_op = 4'd0;
        endcase
        state_d = S_IWB;
      end
      S_IWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        alu_op          = 4'd1;
        pc_write_cond_c = 1'b1;
        pc_src          = 2'd1;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        pc_src     = 2'd2;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Only a stalled memory state keeps counting; every other cycle is a
    // state change, so the counter falls back to zero. On expiry the
    // instruction is dropped (no enables were raised while stalled).
    if (waiting) begin
      if (wait_q == WAIT_LAST) begin
        state_d   = S_FETCH;
        timeout_d = 1'b1;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
  end

  // Reset forces the FSM to FETCH, which itself asserts mem_read, so all
  // enables are also gated combinationally by rst_n to stop writes at once.
  assign pc_write      = pc_write_c      & rst_n;
  assign pc_write_cond = pc_write_cond_c & rst_n;
  assign ir_write      = ir_write_c      & rst_n;
  assign mem_read      = mem_read_c      & rst_n;
  assign mem_write     = mem_write_c     & rst_n;
  assign reg_write     = reg_write_c     & rst_n;

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign mem_timeout = timeout_q;

`ifdef MCC_PERF_CNT_EN
  logic [31:0] instr_count_q;
  logic        retire;

  // An instruction retires when one of the final states completes normally;
  // timeout aborts and illegal decodes are excluded.
  always_comb begin
    retire = 1'b0;
    if (state_d == S_FETCH && !timeout_d) begin
      case (state_q)
        S_MEMWB, S_MEMWR, S_RWB, S_IWB, S_BRANCH, S_JUMP: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)      instr_count_q <= 32'd0;
    else if (retire) instr_count_q <= instr_count_q + 32'd1;
  end

  assign instr_count = instr_count_q;
`else
  assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller. A route-based reference model
// (each opcode maps to a list of states after DECODE, memory states stall on
// mem_ready) predicts state, controls, error pulses and instr_count every
// cycle. Directed sequences are followed by randomized opcodes, mem_ready
// patterns and occasional resets.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam int TO = 15;

  localparam int FETCH  = 0;
  localparam int DECODE = 1;
  localparam int MEMADR = 2;
  localparam int MEMRD  = 3;
  localparam int MEMWB  = 4;
  localparam int MEMWR  = 5;
  localparam int EXEC   = 6;
  localparam int RWB    = 7;
  localparam int IEXEC  = 8;
  localparam int IWB    = 9;
  localparam int BRANCH = 10;
  localparam int JUMP   = 11;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b100111;
  localparam logic [5:0] OP_ANDI  = 6'b101111;
  localparam logic [5:0] OP_ORI   = 6'b110010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       pcW, pcWC, irW, iOrD, memR, memW, memToReg, regDst, regW, srcA;
    logic [1:0] pcSrc, srcB;
    logic [3:0] aluOp;
  } ctrl_t;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic        mem_toreg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  pc_src, alu_src_b;
  logic [3:0]  alu_op, state;
  logic        illegal, mem_timeout;
  logic [31:0] instr_count;

  multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
    .CLK(CLK), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .mem_toreg(mem_toreg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .pc_src(pc_src), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .illegal(illegal),
    .mem_timeout(mem_timeout), .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  ctrl_t obsCtrl;
  assign obsCtrl = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                    mem_toreg, reg_dst, reg_write, alu_src_a, pc_src, alu_src_b, alu_op};

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state
  int          expState;
  logic [5:0]  expOp;
  int          expWait;
  logic        expIllegal, expTimeout;
  logic [31:0] expCount;
  int          route[$];

  // Observation tallies for directed checks
  int obsRegW, obsMemW, obsIrW, obsIll, obsTo;
  int obsStates[$];

  logic [5:0] legalOps [9] = '{OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_SUBI,
                               OP_ANDI, OP_ORI, OP_BEQ, OP_J};

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Controls each state is supposed to drive; anything unlisted stays 0.
  function automatic ctrl_t expCtrl(input int st, input logic mr, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      FETCH:  begin c.memR = 1'b1; c.srcB = 2'd1; c.irW = mr; c.pcW = mr; end
      DECODE: c.srcB = 2'd3;
      MEMADR: begin c.srcA = 1'b1; c.srcB = 2'd2; end
      MEMRD:  begin c.memR = 1'b1; c.iOrD = 1'b1; end
      MEMWB:  begin c.regW = 1'b1; c.memToReg = 1'b1; end
      MEMWR:  begin c.iOrD = 1'b1; c.memW = mr; end
      EXEC:   begin c.srcA = 1'b1; c.aluOp = 4'd15; end
      RWB:    begin c.regW = 1'b1; c.regDst = 1'b1; end
      IEXEC: begin
        c.srcA = 1'b1;
        c.srcB = 2'd2;
        if (op == OP_ADDI)      c.aluOp = 4'd2;
        else if (op == OP_SUBI) c.aluOp = 4'd3;
        else if (op == OP_ANDI) c.aluOp = 4'd4;
        else                    c.aluOp = 4'd5;
      end
      IWB:    c.regW = 1'b1;
      BRANCH: begin c.srcA = 1'b1; c.aluOp = 4'd1; c.pcWC = 1'b1; c.pcSrc = 2'd1; end
      JUMP:   begin c.pcW = 1'b1; c.pcSrc = 2'd2; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // States an instruction visits after DECODE; empty means undefined opcode.
  task automatic loadRoute(input logic [5:0] op);
    route.delete();
    case (op)
      OP_LW:    begin route.push_back(MEMADR); route.push_back(MEMRD); route.push_back(MEMWB); end
      OP_SW:    begin route.push_back(MEMADR); route.push_back(MEMWR); end
      OP_RTYPE: begin route.push_back(EXEC); route.push_back(RWB); end
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin route.push_back(IEXEC); route.push_back(IWB); end
      OP_BEQ:   route.push_back(BRANCH);
      OP_J:     route.push_back(JUMP);
      default:  route.delete();
    endcase
  endtask

  task automatic resetModel();
    expState   = FETCH;
    expWait    = 0;
    expIllegal = 1'b0;
    expTimeout = 1'b0;
    expCount   = 32'd0;
    route.delete();
  endtask

  task automatic advanceModel(input logic [5:0] op, input logic mr);
    int   nxt;
    logic nIll, nTo;
    nxt  = expState;
    nIll = 1'b0;
    nTo  = 1'b0;
    if ((expState == FETCH || expState == MEMRD || expState == MEMWR) && !mr) begin
      expWait++;
      if (expWait == TO) begin
        nxt     = FETCH;
        nTo     = 1'b1;
        expWait = 0;
        route.delete();
      end
    end else begin
      expWait = 0;
      if (expState == FETCH) begin
        route.delete();
        route.push_back(DECODE);
      end else if (expState == DECODE) begin
        expOp = op;
        loadRoute(op);
        if (route.size() == 0) nIll = 1'b1;
      end
      if (route.size() != 0) begin
        nxt = route.pop_front();
      end else begin
        nxt = FETCH;
`ifdef MCC_PERF_CNT_EN
        if (expState != DECODE) expCount = expCount + 32'd1;
`endif
      end
    end
    expState   = nxt;
    expIllegal = nIll;
    expTimeout = nTo;
  endtask

  task automatic clearTallies();
    obsRegW = 0; obsMemW = 0; obsIrW = 0; obsIll = 0; obsTo = 0;
    obsStates.delete();
  endtask

  // One clock cycle: drive on the falling edge, check 1ns later, then let
  // the model follow the rising edge that comes next.
  task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic mr);
    ctrl_t e;
    @(negedge CLK);
    rst_n     = rst;
    opcode    = op;
    mem_ready = mr;
    #1;
    if (!rst) begin
      resetModel();
      e = expCtrl(FETCH, mr, expOp);
      e.pcW = 1'b0; e.pcWC = 1'b0; e.irW = 1'b0;
      e.memR = 1'b0; e.memW = 1'b0; e.regW = 1'b0;
    end else begin
      e = expCtrl(expState, mr, expOp);
    end
    checkOutput("state", 64'(state), 64'(expState));
    checkOutput("ctrl", 64'(obsCtrl), 64'(e));
    checkOutput("illegal", 64'(illegal), 64'(expIllegal));
    checkOutput("mem_timeout", 64'(mem_timeout), 64'(expTimeout));
    checkOutput("instr_count", 64'(instr_count), 64'(expCount));
    obsRegW += int'(reg_write);
    obsMemW += int'(mem_write);
    obsIrW  += int'(ir_write);
    obsIll  += int'(illegal);
    obsTo   += int'(mem_timeout);
    obsStates.push_back(int'(state));
    if (rst) advanceModel(op, mr);
  endtask

  initial begin
    int         rtypeSeq[5];
    int         memrdCycles;
    int         readyPct;
    logic [5:0] op;
    logic       mr, rs;

    rtypeSeq = '{0, 1, 6, 7, 0};
    rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b0;
    expOp = 6'd0;
    resetModel();

    // Reset held for 3 cycles, then RTYPE with mem_ready high.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, OP_RTYPE, 1'b1);
    clearTallies();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, OP_RTYPE, 1'b1);
    for (int i = 0; i < 5; i++) checkOutput("rtype_state_seq", 64'(obsStates[i]), 64'(rtypeSeq[i]));
    checkOutput("rtype_regw_count", 64'(obsRegW), 64'd1);

    // LW with a 4-cycle memory stall in MEMRD.
    applyStimulus(1'b0, 6'd0, 1'b0);
    clearTallies();
    applyStimulus(1'b1, OP_LW, 1'b1);
    applyStimulus(1'b1, OP_LW, 1'b1);
    applyStimulus(1'b1, 6'h3F, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 6'h3F, 1'b0);
    applyStimulus(1'b1, 6'h3F, 1'b1);
    applyStimulus(1'b1, 6'h3F, 1'b1);
    applyStimulus(1'b1, 6'h3F, 1'b0);
    memrdCycles = 0;
    foreach (obsStates[i]) if (obsStates[i] == MEMRD) memrdCycles++;
    checkOutput("lw_memrd_cycles", 64'(memrdCycles), 64'd5);
    checkOutput("lw_regw_count", 64'(obsRegW), 64'd1);

    // SW followed by BEQ.
    applyStimulus(1'b0, 6'd0, 1'b0);
    clearTallies();
    applyStimulus(1'b1, OP_SW, 1'b1);
    applyStimulus(1'b1, OP_SW, 1'b1);
    applyStimulus(1'b1, OP_J, 1'b1);
    applyStimulus(1'b1, OP_J, 1'b1);
    applyStimulus(1'b1, OP_BEQ, 1'b1);
    applyStimulus(1'b1, OP_BEQ, 1'b1);
    applyStimulus(1'b1, OP_LW, 1'b1);
    checkOutput("beq_branch_ctrl", 64'({state, pc_write_cond, alu_op, pc_src}),
                64'({4'd10, 1'b1, 4'd1, 2'd1}));
    applyStimulus(1'b1, OP_LW, 1'b0);
    checkOutput("sw_memw_count", 64'(obsMemW), 64'd1);

    // Undefined opcode.
    applyStimulus(1'b0, 6'd0, 1'b0);
    clearTallies();
    applyStimulus(1'b1, 6'h3F, 1'b1);
    applyStimulus(1'b1, 6'h3F, 1'b1);
    applyStimulus(1'b1, 6'h3F, 1'b0);
    applyStimulus(1'b1, 6'h3F, 1'b0);
    checkOutput("illegal_pulse_count", 64'(obsIll), 64'd1);
    checkOutput("illegal_state_seq", 64'({obsStates[0], obsStates[1], obsStates[2]}),
                64'({32'(0), 32'(1), 32'(0)}) & 64'hFFFF_FFFF_FFFF_FFFF);

    // Fetch starved of mem_ready until the wait limit expires.
    applyStimulus(1'b0, 6'd0, 1'b0);
    clearTallies();
    for (int i = 0; i < TO; i++) applyStimulus(1'b1, OP_LW, 1'b0);
    checkOutput("timeout_not_early", 64'(obsTo), 64'd0);
    applyStimulus(1'b1, OP_LW, 1'b0);
    checkOutput("timeout_pulse", 64'(mem_timeout), 64'd1);
    applyStimulus(1'b1, OP_LW, 1'b0);
    checkOutput("timeout_pulse_count", 64'(obsTo), 64'd1);
    checkOutput("timeout_no_irwrite", 64'(obsIrW), 64'd0);

`ifdef MCC_PERF_CNT_EN
    // Counter wrap: preload near the top, retire three jumps.
    applyStimulus(1'b0, 6'd0, 1'b0);
    applyStimulus(1'b1, 6'd0, 1'b0);
    dut.instr_count_q = 32'hFFFF_FFFE;
    expCount = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, OP_J, 1'b1);
      applyStimulus(1'b1, OP_J, 1'b1);
      applyStimulus(1'b1, OP_J, 1'b1);
    end
    applyStimulus(1'b1, 6'd0, 1'b0);
    checkOutput("count_wrap", 64'(instr_count), 64'd1);
`endif

    // Reset asserted while a store is completing must kill mem_write at once.
    applyStimulus(1'b0, 6'd0, 1'b0);
    applyStimulus(1'b1, OP_SW, 1'b1);
    applyStimulus(1'b1, OP_SW, 1'b1);
    applyStimulus(1'b1, 6'd0, 1'b1);
    @(negedge CLK);
    mem_ready = 1'b1;
    #1;
    checkOutput("memwr_state", 64'(state), 64'd5);
    checkOutput("memwr_write_before_reset", 64'(mem_write), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("memwr_write_in_reset", 64'(mem_write), 64'd0);
    checkOutput("memwr_state_in_reset", 64'(state), 64'd0);
    resetModel();
    applyStimulus(1'b0, 6'd0, 1'b0);

    // Randomized traffic with varying memory latency and rare resets.
    readyPct = 90;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) begin
        case ($urandom_range(0, 2))
          0:       readyPct = 90;
          1:       readyPct = 50;
          default: readyPct = 8;
        endcase
      end
      if ($urandom_range(0, 9) < 8) op = legalOps[$urandom_range(0, 8)];
      else                          op = 6'($urandom_range(0, 63));
      mr = ($urandom_range(0, 99) < readyPct);
      rs = ($urandom_range(0, 199) != 0);
      applyStimulus(rs, op, mr);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
